mem_stage: RTL and testbench

- Memory stage of the 5-stage ARM pipeline, directly downstream of the execute stage.
- Latches the execute-stage outputs (ALUResultE, WriteDataE, RdE, RegWriteE, MemtoRegE, MemWriteE) into the E/M pipeline register.
- Runs the word access to data memory over a req/ack handshake and raises a stall while memory is slow.
- Supplies ALUResultM for forwarding and presents results to the writeback register.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_wait_ctr.sv | 27 ++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: access FSM states, error codes, default timeout.
package mem_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ABORT = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_MISALIGN = 2'b10;

   localparam int MAX_WAIT_DEF = 15;
endpackage

// File: rtl/mem_wait_ctr.sv
// Saturating wait counter; hit flags the increment that brings the count up to LIMIT.
module mem_wait_ctr #(
   parameter int LIMIT = 15,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt;

   assign hit = inc & (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: E/M pipeline register, req/ack data-memory access with timeout abort,
// misalignment suppression and a sticky first-error register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic [3:0]  RdE,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        err_clr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        StallM,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic [3:0]  RdM,
   output logic [31:0] ALUResultM,
   output logic [31:0] ReadDataM,
   output logic        err,
   output logic [1:0]  err_code
);
   logic        reg_write_q;
   logic        mem_to_reg_q;
   logic        mem_write_q;
   logic [3:0]  rd_q;
   logic [31:0] alu_q;
   logic [31:0] wdata_q;

   state_t      state_q;
   state_t      state_d;

   logic        memop;
   logic        misaligned;
   logic        in_abort;
   logic        wait_inc;
   logic        wait_clr;
   logic        wait_hit;
   logic        err_new;
   logic [1:0]  code_new;

   // E/M register: holds while stalled so an issued access is never cancelled by flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         rd_q         <= '0;
         alu_q        <= '0;
         wdata_q      <= '0;
      end else if (!StallM) begin
         reg_write_q  <= RegWriteE & ~flush;
         mem_to_reg_q <= MemtoRegE & ~flush;
         mem_write_q  <= MemWriteE & ~flush;
         rd_q         <= RdE;
         alu_q        <= ALUResultE;
         wdata_q      <= WriteDataE;
      end
   end

   assign memop      = mem_to_reg_q | mem_write_q;
   assign misaligned = memop & (alu_q[1:0] != 2'b00);
   assign in_abort   = (state_q == ABORT);

   assign mem_req    = memop & ~misaligned & ~in_abort;
   assign mem_we     = mem_write_q;
   assign mem_addr   = alu_q;
   assign mem_wdata  = wdata_q;
   assign StallM     = mem_req & ~mem_ack;

   assign RegWriteM  = reg_write_q  & ~misaligned & ~in_abort;
   assign MemtoRegM  = mem_to_reg_q & ~misaligned & ~in_abort;
   assign RdM        = rd_q;
   assign ALUResultM = alu_q;
   assign ReadDataM  = mem_ack ? mem_rdata : 32'h0;

   assign wait_inc = StallM;
   assign wait_clr = ~wait_inc | wait_hit;

   mem_wait_ctr #(
      .LIMIT (MAX_WAIT),
      .CNT_W (CNT_W)
   ) u_wait_ctr (
      .clk   (clk),
      .rst_n (reset),
      .inc   (wait_inc),
      .clr   (wait_clr),
      .hit   (wait_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wait_hit) begin
               state_d = ABORT;
            end else if (StallM) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wait_hit) begin
               state_d = ABORT;
            end else if (!StallM) begin
               state_d = IDLE;
            end
         end
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A misaligned op never requests, so it cannot coincide with a timeout.
   assign err_new  = misaligned | wait_hit;
   assign code_new = misaligned ? ERR_MISALIGN : ERR_TIMEOUT;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (err_new && (!err || err_clr)) begin
         err      <= 1'b1;
         err_code <= code_new;
      end else if (err_clr) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_stage;
   localparam int MAXW = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        RegWriteE = 1'b0, MemtoRegE = 1'b0, MemWriteE = 1'b0;
   logic [3:0]  RdE = '0;
   logic [31:0] ALUResultE = '0, WriteDataE = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        err_clr = 1'b0;

   logic        mem_req, mem_we, StallM, RegWriteM, MemtoRegM, err;
   logic [31:0] mem_addr, mem_wdata, ALUResultM, ReadDataM;
   logic [3:0]  RdM;
   logic [1:0]  err_code;

   always #5 clk = ~clk;

   mem_stage #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_clr(err_clr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .StallM(StallM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .RdM(RdM),
      .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .err(err), .err_code(err_code)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: the instruction held in M, whether it is retiring after a timeout,
   // how long it has waited, and the sticky error.
   bit          m_rw, m_mtr, m_mw, m_dc, m_abort, m_err;
   logic [3:0]  m_rd;
   logic [31:0] m_alu, m_wd;
   logic [1:0]  m_code;
   int          m_waited;
   bit          obs_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rw = 0; m_mtr = 0; m_mw = 0; m_dc = 0; m_abort = 0; m_err = 0;
      m_rd = '0; m_alu = '0; m_wd = '0; m_code = 2'b00; m_waited = 0;
   endtask

   task automatic check_outputs();
      bit memop, mis, req, stall;
      memop = m_mtr | m_mw;
      mis   = memop && (m_alu % 4 != 0);
      req   = memop && !mis && !m_abort;
      stall = req && !mem_ack;
      chk("mem_req",   mem_req,   req);
      chk("StallM",    StallM,    stall);
      chk("mem_we",    mem_we,    m_mw);
      chk("RegWriteM", RegWriteM, m_rw && !mis && !m_abort);
      chk("MemtoRegM", MemtoRegM, m_mtr && !mis && !m_abort);
      chk("ReadDataM", ReadDataM, mem_ack ? mem_rdata : 32'h0);
      chk("err",       err,       m_err);
      chk("err_code",  err_code,  m_code);
      if (!m_dc) begin
         chk("RdM",        RdM,        m_rd);
         chk("ALUResultM", ALUResultM, m_alu);
         chk("mem_addr",   mem_addr,   m_alu);
         chk("mem_wdata",  mem_wdata,  m_wd);
      end
   endtask

   task automatic model_edge();
      bit memop, mis, req, stall, tmo;
      logic [1:0] newc;
      memop = m_mtr | m_mw;
      mis   = memop && (m_alu % 4 != 0);
      req   = memop && !mis && !m_abort;
      stall = req && !mem_ack;
      tmo   = 0;
      if (stall) begin
         m_waited++;
         if (m_waited == MAXW) begin
            tmo = 1;
            m_waited = 0;
         end
      end else begin
         m_waited = 0;
      end
      newc = mis ? 2'b10 : (tmo ? 2'b01 : 2'b00);
      if (newc != 2'b00 && (!m_err || err_clr)) begin
         m_err = 1; m_code = newc;
      end else if (err_clr) begin
         m_err = 0; m_code = 2'b00;
      end
      m_abort = tmo;
      if (!stall) begin
         m_rw  = RegWriteE && !flush;
         m_mtr = MemtoRegE && !flush;
         m_mw  = MemWriteE && !flush;
         m_dc  = flush;
         m_rd  = RdE; m_alu = ALUResultE; m_wd = WriteDataE;
      end
   endtask

   // Inputs are set just after a falling edge; outputs are checked 1 ns later.
   task automatic cycle();
      #1;
      check_outputs();
      obs_stall = StallM;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_e(input bit rw, input bit mtr, input bit mw, input logic [3:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd);
      RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw;
      RdE = rd; ALUResultE = alu; WriteDataE = wd;
   endtask

   initial begin
      int n;
      int noack_left;
      model_reset();
      @(negedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      reset = 1'b1;

      // zero-wait load
      set_e(1, 1, 0, 4'd3, 32'h100, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      cycle();
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      #1;
      chk("load_rdata", ReadDataM, 32'hDEADBEEF);
      chk("load_rd", RdM, 32'd3);
      chk("load_stall", StallM, 0);
      cycle();

      // store with 3-cycle ack delay
      set_e(0, 0, 1, 4'd0, 32'h200, 32'h12345678);
      cycle();
      set_e(1, 0, 0, 4'd5, 32'h44, 32'h0);
      mem_ack = 1'b0;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (obs_stall) n++;
      end
      chk("store_we", mem_we, 1);
      chk("store_addr", mem_addr, 32'h200);
      mem_ack = 1'b1;
      cycle();
      if (obs_stall) n++;
      chk("store_stall_cycles", n, 3);
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      cycle();

      // timeout
      set_e(1, 1, 0, 4'd7, 32'h104, 32'h0);
      cycle();
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      mem_ack = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (obs_stall) n++;
         else break;
      end
      chk("timeout_stall_cycles", n, MAXW);
      chk("timeout_code", err_code, 2'b01);
      cycle();

      // misaligned after clearing, then a timeout must not overwrite it
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      chk("clr_err", err, 0);
      set_e(1, 1, 0, 4'd2, 32'h102, 32'h0);
      cycle();
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      cycle();
      chk("misalign_code", err_code, 2'b10);
      set_e(1, 1, 0, 4'd2, 32'h108, 32'h0);
      cycle();
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      for (int i = 0; i < MAXW + 2; i++) cycle();
      chk("first_err_wins", err_code, 2'b10);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      chk("clr_err2", err, 0);

      // flush during a stalled store, then on the next free edge
      set_e(0, 0, 1, 4'd0, 32'h300, 32'hCAFEF00D);
      cycle();
      set_e(1, 1, 0, 4'd9, 32'h400, 32'h0);
      flush = 1'b1;
      for (int i = 0; i < 2; i++) cycle();
      chk("flush_store_held", mem_addr, 32'h300);
      mem_ack = 1'b1;
      cycle();
      flush = 1'b0;
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      chk("flush_bubble", RegWriteM, 0);
      cycle();

      // asynchronous reset in the middle of WAIT
      set_e(1, 1, 0, 4'd4, 32'h500, 32'h0);
      mem_ack = 1'b0;
      cycle();
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      cycle();
      cycle();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_req", mem_req, 0);
      chk("rst_stall", StallM, 0);
      check_outputs();
      @(negedge clk);
      reset = 1'b1;
      set_e(1, 1, 0, 4'd6, 32'h600, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      cycle();
      set_e(0, 0, 0, 4'd0, 32'h0, 32'h0);
      cycle();

      // random traffic
      noack_left = 0;
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         set_e(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
         flush = ($urandom_range(0, 7) == 0);
         err_clr = ($urandom_range(0, 15) == 0);
         if (noack_left == 0 && $urandom_range(0, 40) == 0) noack_left = $urandom_range(5, 20);
         if (noack_left > 0) begin
            mem_ack = 1'b0;
            noack_left--;
         end else begin
            mem_ack = ($urandom_range(0, 3) != 0);
         end
         mem_rdata = $urandom;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
